fifo_umbral: RTL and testbench

Synchronous single-clock FIFO with programmable almost-full / almost-empty thresholds, instantiated per queue (main, virtual-channel and destination FIFOs) in the PCIe QoS datapath. It consumes the per-FIFO HIGH/LOW thresholds driven by the QoS control state machine. It returns to that controller the `empty` and `error` bits that form its `FIFO_EMPTIES` / `FIFO_ERRORS` inputs. Upstream logic uses `almost_full` for flow control. Downstream arbiters use `almost_empty` to throttle.

---
 rtl/fifo_umbral.sv | 73 +++++++
 tb/tb_fifo_umbral.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/fifo_umbral.sv
// Single-clock FIFO with live almost-full/almost-empty thresholds and an error flag.
// Define FIFO_ERR_STICKY_EN for a sticky error flag; otherwise error is a one-cycle pulse.
module fifo_umbral #(
  parameter int DATA_W = 6,
  parameter int ADDR_W = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic [DATA_W-1:0] data_in,
  input  logic              pop,
  input  logic [ADDR_W:0]   umbral_high,
  input  logic [ADDR_W:0]   umbral_low,
  output logic [DATA_W-1:0] data_out,
  output logic              valid_out,
  output logic              empty,
  output logic              full,
  output logic              almost_full,
  output logic              almost_empty,
  output logic              error
);
  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0] DEPTH_C = DEPTH[ADDR_W:0];

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic [ADDR_W:0]   count;
  logic              do_push, do_pop, ovf, udf, err_evt;

  assign empty        = (count == '0);
  assign full         = (count == DEPTH_C);
  assign almost_full  = (umbral_high != '0) && (count >= umbral_high);
  assign almost_empty = (count <= umbral_low);

  // A pop on an empty FIFO never falls through to a same-cycle push.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign ovf     = push && full && !pop;
  assign udf     = pop && empty;
  assign err_evt = ovf || udf;

  always_ff @(posedge clk) begin
    if (do_push && !reset) mem[wr_ptr] <= data_in;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      data_out  <= '0;
      valid_out <= 1'b0;
      error     <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) begin
        rd_ptr   <= rd_ptr + 1'b1;
        data_out <= mem[rd_ptr];
      end
      valid_out <= do_pop;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
`ifdef FIFO_ERR_STICKY_EN
      error <= error || err_evt;
`else
      error <= err_evt;
`endif
    end
  end
endmodule

// File: tb/tb_fifo_umbral.sv
// Self-checking bench: directed scenarios plus random traffic against a queue-based model.
module tb_fifo_umbral;
  localparam int DATA_W = 6;
  localparam int ADDR_W = 2;
  localparam int DEPTH  = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              reset = 1'b0, push = 1'b0, pop = 1'b0;
  logic [DATA_W-1:0] data_in = '0;
  logic [ADDR_W:0]   umbral_high = '0, umbral_low = '0;
  logic [DATA_W-1:0] data_out;
  logic              valid_out, empty, full, almost_full, almost_empty, error;

  int n_tests = 0, n_fail = 0;

  logic [DATA_W-1:0] q[$];
  logic [DATA_W-1:0] m_dout = '0;
  logic              m_vld = 1'b0, m_err = 1'b0;

  fifo_umbral #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset), .push(push), .data_in(data_in), .pop(pop),
    .umbral_high(umbral_high), .umbral_low(umbral_low),
    .data_out(data_out), .valid_out(valid_out), .empty(empty), .full(full),
    .almost_full(almost_full), .almost_empty(almost_empty), .error(error)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_step(input logic ps, input logic [DATA_W-1:0] d, input logic pp, input logic rs);
    logic ovf, udf;
    if (rs) begin
      q.delete();
      m_dout = '0; m_vld = 1'b0; m_err = 1'b0;
      return;
    end
    ovf = ps && (q.size() == DEPTH) && !pp;
    udf = pp && (q.size() == 0);
    if (pp && q.size() > 0) begin
      m_dout = q.pop_front();
      m_vld  = 1'b1;
    end else m_vld = 1'b0;
    if (ps && !ovf) q.push_back(d);
`ifdef FIFO_ERR_STICKY_EN
    m_err = m_err || ovf || udf;
`else
    m_err = ovf || udf;
`endif
  endtask

  task automatic check_all(input string tag);
    int n;
    n = q.size();
    check({tag, ".data_out"},     32'(data_out),     32'(m_dout));
    check({tag, ".valid_out"},    32'(valid_out),    32'(m_vld));
    check({tag, ".empty"},        32'(empty),        32'(n == 0));
    check({tag, ".full"},         32'(full),         32'(n == DEPTH));
    check({tag, ".almost_full"},  32'(almost_full),  32'((umbral_high != 0) && (n >= int'(umbral_high))));
    check({tag, ".almost_empty"}, 32'(almost_empty), 32'(n <= int'(umbral_low)));
    check({tag, ".error"},        32'(error),        32'(m_err));
  endtask

  task automatic cycle(input string tag, input logic ps, input logic [DATA_W-1:0] d,
                       input logic pp, input logic rs);
    push = ps; data_in = d; pop = pp; reset = rs;
    @(posedge clk);
    model_step(ps, d, pp, rs);
    #1;
    push = 1'b0; pop = 1'b0; reset = 1'b0;
    check_all(tag);
  endtask

  initial begin
    // reset state
    umbral_high = 3'd0; umbral_low = 3'd0;
    cycle("reset", 0, 0, 0, 1);
    check("reset.af_thr7", 32'(almost_full), 32'(0));
    umbral_high = 3'd7; #1;
    check("reset.af_thr7b", 32'(almost_full), 32'(0));
    umbral_high = 3'd0;

    // fill and drain in order
    for (int i = 1; i <= 4; i++) cycle("fill", 1, DATA_W'(i), 0, 0);
    check("fill.full", 32'(full), 32'(1));
    for (int i = 1; i <= 4; i++) begin
      cycle("drain", 0, 0, 1, 0);
      check("drain.order", 32'(data_out), 32'(i));
    end
    check("drain.empty", 32'(empty), 32'(1));

    // thresholds
    umbral_high = 3'd3; umbral_low = 3'd1;
    for (int i = 0; i < 3; i++) cycle("thr", 1, DATA_W'(8 + i), 0, 0);
    check("thr.af", 32'(almost_full), 32'(1));
    umbral_high = 3'd0; #1;
    check("thr.af_disabled", 32'(almost_full), 32'(0));
    check_all("thr.live");
    cycle("thr.top", 1, 6'h0B, 0, 0);

    // overflow: dropped word, data preserved
    cycle("ovf", 1, 6'h3F, 0, 0);
    check("ovf.err", 32'(error), 32'(1));
    cycle("ovf.idle", 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) cycle("ovf.drain", 0, 0, 1, 0);
    check("ovf.last", 32'(data_out), 32'(6'h0B));

    // push+pop on full
    for (int i = 0; i < 4; i++) cycle("pf.fill", 1, DATA_W'(16 + i), 0, 0);
    cycle("pf.both", 1, 6'h2A, 1, 0);
    check("pf.oldest", 32'(data_out), 32'(16));
    check("pf.full", 32'(full), 32'(1));
    for (int i = 0; i < 4; i++) cycle("pf.drain", 0, 0, 1, 0);
    check("pf.last", 32'(data_out), 32'(6'h2A));

    // push+pop on empty
    cycle("pe.both", 1, 6'h15, 1, 0);
    check("pe.err", 32'(error), 32'(1));
    check("pe.vld", 32'(valid_out), 32'(0));
    cycle("pe.pop", 0, 0, 1, 0);
    check("pe.data", 32'(data_out), 32'(6'h15));

    // reset mid-operation
    cycle("rm.p0", 1, 6'h01, 0, 0);
    cycle("rm.p1", 1, 6'h02, 0, 0);
    cycle("rm.rst", 0, 0, 1, 1);
    check("rm.empty", 32'(empty), 32'(1));
    check("rm.dout", 32'(data_out), 32'(0));

    // random traffic
    for (int i = 0; i < 600; i++) begin
      if (i % 16 == 0) begin
        umbral_high = ADDR_W'(0) + 3'($urandom_range(0, 7));
        umbral_low  = 3'($urandom_range(0, 7));
      end
      cycle("rnd", 1'($urandom_range(0, 99) < 55), DATA_W'($urandom),
            1'($urandom_range(0, 99) < 45), 1'($urandom_range(0, 99) < 2));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
